rbit_src: RTL and testbench
===========================

Name: rbit_src

Overview:
- Pseudo-random bit source that sits directly upstream of the cookie block and drives its rbit input.
- 16-bit maximal-length Fibonacci LFSR, with a seedable state and a warm-up discard phase.
- A repetition-count health test detects a stuck bit stream.
- Presents rbit with an rbit_valid qualifier; cookie samples rbit, which holds its last value whenever it is not valid.

Parameters:
- DEFAULT_SEED, 16'hACE1, LFSR state after reset; also substituted whenever a zero seed is loaded.
- WARMUP, 16, number of LFSR steps discarded after leaving IDLE or after a seed load. Range 1..255.
- REP_LIMIT, 20, count of consecutive identical raw bits that trips the stuck flag. Range 2..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- en  in  1  run enable
- seed_load  in  1  load seed into the LFSR (one-cycle pulse)
- seed  in  16  seed value
- rbit  out  1  random bit to cookie
- rbit_valid  out  1  rbit updated this cycle
- stuck  out  1  sticky health-test failure

Behaviour:
- Reset (rst_n low at a rising edge) sets:
  - lfsr=DEFAULT_SEED, state=IDLE, warm_cnt=0, rep_cnt=0;
  - rbit=0, rbit_valid=0, stuck=0, vn_phase=0.
- LFSR step:
  - fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]; lfsr <= {lfsr[14:0], fb}.
  - raw = fb, which is the new lfsr[0].
  - The LFSR steps only in WARM and RUN; it holds in IDLE.
- FSM:
  - IDLE: rbit_valid=0. If en=1 → WARM, warm_cnt=0.
  - WARM: step every cycle and increment warm_cnt. rbit_valid=0. When warm_cnt reaches WARMUP-1 → RUN. If en=0 → IDLE with warm_cnt cleared; the LFSR keeps its state.
  - RUN: step every cycle, rbit<=raw, rbit_valid<=1. If en=0 → IDLE; rbit_valid goes 0 on the next edge and rbit holds.
- Latency: with en held high from IDLE, rbit_valid first reads 1 after rising edge number WARMUP+2, counting the IDLE→WARM edge as edge 1.
- seed_load has highest priority (below reset), in any state:
  - lfsr <= (seed==0) ? DEFAULT_SEED : seed;
  - clears warm_cnt, rep_cnt, stuck, vn_phase; rbit_valid <= 0;
  - next state is WARM if en=1, else IDLE;
  - en changes in the same cycle are honoured as above.
- Health test, RUN only:
  - rep_cnt counts consecutive equal raw values and restarts at 1 on a change.
  - When rep_cnt reaches REP_LIMIT, stuck<=1. stuck is sticky until reset or seed_load.
  - While stuck=1, rbit_valid is forced 0, rbit holds, and the LFSR keeps stepping.
  - With the defaults the test never trips on a healthy LFSR, because the longest run is 16.
- The all-zero LFSR state is unreachable: reset and seed_load both substitute DEFAULT_SEED for zero.

Optional Feature:
- Macro RBIT_VN_EN selects von Neumann debiasing in RUN.
- Defined:
  - raw bits are taken in pairs, toggling vn_phase each RUN cycle;
  - phase 0 stores raw in hold, rbit_valid=0;
  - phase 1: if hold!=raw, rbit<=hold and rbit_valid<=1; otherwise rbit_valid=0 and rbit holds;
  - vn_phase clears on leaving RUN.
- Undefined: one valid bit per RUN cycle, and vn_phase/hold are not implemented.
- The health test is identical in both builds.

Decomposition:
- Package rbit_pkg holds:
  - the state enum {IDLE, WARM, RUN};
  - LFSR width 16, the tap positions, and DEFAULT_SEED localparam.
- Sub-module rbit_lfsr: 16-bit register with load/step/hold and a zero-seed substitution output of raw.
- rbit_src contains the FSM, counters, health test and VN logic.

Test Plan:
- Reset, en=1 (WARMUP=16): rbit_valid=0 through edge 17 and 1 at edge 18. The first LFSR step from 0xACE1 gives 0x59C3.
- seed_load with seed=0x0000: LFSR=0xACE1, and the rbit sequence is identical to the post-reset sequence.
- en dropped for 5 cycles in RUN: rbit_valid=0 from the next edge and the LFSR is frozen. On re-enable, WARMUP is repeated and the sequence resumes from the frozen state.
- REP_LIMIT=3: stuck asserts on the third equal raw bit and rbit_valid is forced to 0. seed_load=0x1234 clears stuck and restarts WARM.
- seed_load in the same cycle as the WARM→RUN transition: seed wins, the bench observes a fresh WARMUP, and there is no valid output in between.
- RBIT_VN_EN build: the bench compares against a reference pair model. rbit_valid is never asserted on consecutive cycles, and emitted bits equal the first bit of each unequal pair.

Source files
------------

// File: rtl/rbit_pkg.sv
// rbit_pkg: shared types and constants for the pseudo-random bit source.
//   state_t            FSM encoding {IDLE, WARM, RUN}
//   LFSR_W             LFSR width (16)
//   TAP_*              Fibonacci feedback taps x^16+x^14+x^13+x^11+1
//   LFSR_DEFAULT_SEED  state after reset and replacement for a zero seed
//   CNT_W              width of the warm-up and repetition counters
//   lfsr_fb()          feedback bit for a given LFSR state
package rbit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int LFSR_W = 16;
  localparam int TAP_0  = 15;
  localparam int TAP_1  = 13;
  localparam int TAP_2  = 12;
  localparam int TAP_3  = 10;

  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // WARMUP and REP_LIMIT are both bounded to 255
  localparam int CNT_W = 8;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3];
  endfunction

endpackage

// File: rtl/rbit_src_if.sv
// rbit_src_if: control and output bundle of the random bit source.
//   en          run enable
//   seed_load   one-cycle pulse that loads seed into the LFSR
//   seed        seed value (zero is replaced by the default seed)
//   rbit        random bit towards the cookie block
//   rbit_valid  rbit was updated this cycle
//   stuck       sticky repetition-count health failure
// Modports: master drives the controls, slave is the bit source itself.
interface rbit_src_if;

  logic                        en;
  logic                        seed_load;
  logic [rbit_pkg::LFSR_W-1:0] seed;
  logic                        rbit;
  logic                        rbit_valid;
  logic                        stuck;

  modport master (
    output en, seed_load, seed,
    input  rbit, rbit_valid, stuck
  );

  modport slave (
    input  en, seed_load, seed,
    output rbit, rbit_valid, stuck
  );

endinterface

// File: rtl/rbit_lfsr.sv
// rbit_lfsr: 16-bit maximal-length Fibonacci LFSR with load / step / hold.
//   clk, rst_n  clock and synchronous active-low reset (state -> DEFAULT_SEED)
//   load        load seed; a zero seed is replaced by DEFAULT_SEED so the
//               all-zero lock-up state can never be entered
//   seed        seed value
//   step        advance one position (load has priority)
//   raw         feedback bit, i.e. the bit that becomes lfsr[0] on a step
module rbit_lfsr
  import rbit_pkg::*;
#(
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic              raw
);

  logic [LFSR_W-1:0] lfsr;

  assign raw = lfsr_fb(lfsr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= DEFAULT_SEED;
    end else if (load) begin
      lfsr <= (seed == '0) ? DEFAULT_SEED : seed;
    end else if (step) begin
      lfsr <= {lfsr[LFSR_W-2:0], raw};
    end
  end

endmodule

// File: rtl/rbit_src.sv
// rbit_src: pseudo-random bit source feeding the cookie block.
//   clk, rst_n  clock and synchronous active-low reset
//   bus         rbit_src_if.slave: en, seed_load, seed in; rbit, rbit_valid,
//               stuck out
// Parameters: DEFAULT_SEED (reset / zero-seed value), WARMUP (discarded steps
// after leaving IDLE or a seed load, 1..255), REP_LIMIT (equal raw bits that
// trip stuck, 2..255).
// Build option: define RBIT_VN_EN for von Neumann debiasing of the RUN output
// (raw bits taken in pairs, the first bit of every unequal pair is emitted).
module rbit_src
  import rbit_pkg::*;
#(
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED,
  parameter int                WARMUP       = 16,
  parameter int                REP_LIMIT    = 20
) (
  input  logic      clk,
  input  logic      rst_n,
  rbit_src_if.slave bus
);

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] REP_MAX   = CNT_W'(REP_LIMIT);

  state_t           state;
  state_t           state_nxt;
  logic             step;
  logic             run_step;
  logic             raw;
  logic [CNT_W-1:0] warm_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_nxt;
  logic             last_raw;
  logic             trip;
  logic             stuck_nxt;
  logic             emit;
  logic             emit_bit;
  logic             out_bit;
  logic             out_valid;
  logic             stuck_flag;

  rbit_lfsr #(
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (bus.seed_load),
    .seed (bus.seed),
    .step (step),
    .raw  (raw)
  );

  // Next state and LFSR step enable. Dropping en never steps, so the LFSR
  // is frozen at the state after the last delivered bit.
  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en) state_nxt = WARM;
      end
      WARM: begin
        if (!bus.en) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (warm_cnt == WARM_LAST) state_nxt = RUN;
        end
      end
      RUN: begin
        if (!bus.en) state_nxt = IDLE;
        else         step      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // A seed load overrides everything and restarts the warm-up
    if (bus.seed_load) begin
      state_nxt = bus.en ? WARM : IDLE;
      step      = 1'b0;
    end
  end

  assign run_step = step && (state == RUN);

  // Repetition-count health test on the raw stream seen in RUN. rep_cnt==0
  // means no raw bit has been seen since reset / seed load. The count
  // saturates at REP_MAX so it cannot wrap while stuck.
  always_comb begin
    rep_nxt = rep_cnt;
    if (rep_cnt == '0 || raw != last_raw) begin
      rep_nxt = CNT_W'(1);
    end else if (rep_cnt != REP_MAX) begin
      rep_nxt = rep_cnt + CNT_W'(1);
    end
    trip      = run_step && (rep_nxt == REP_MAX);
    stuck_nxt = stuck_flag || trip;
  end

`ifdef RBIT_VN_EN
  logic vn_phase;
  logic hold;

  // Phase 0 stores the first bit of the pair, phase 1 emits it when the
  // pair differs. The phase is cleared whenever a cycle is not a RUN step.
  assign emit     = run_step && vn_phase && (hold != raw);
  assign emit_bit = hold;

  always_ff @(posedge clk) begin
    if (!rst_n) vn_phase <= 1'b0;
    else        vn_phase <= run_step ? ~vn_phase : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (run_step && !vn_phase) hold <= raw;
  end
`else
  assign emit     = run_step;
  assign emit_bit = raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      warm_cnt   <= '0;
      rep_cnt    <= '0;
      last_raw   <= 1'b0;
      stuck_flag <= 1'b0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Counts only while staying in WARM; any exit or seed load clears it
      warm_cnt <= (step && state == WARM && state_nxt == WARM) ?
                  warm_cnt + CNT_W'(1) : '0;
      if (bus.seed_load) begin
        rep_cnt    <= '0;
        stuck_flag <= 1'b0;
        out_valid  <= 1'b0;
      end else begin
        if (run_step) begin
          rep_cnt  <= rep_nxt;
          last_raw <= raw;
        end
        stuck_flag <= stuck_nxt;
        // The tripping cycle itself already suppresses the output
        if (emit && !stuck_nxt) begin
          out_bit   <= emit_bit;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.rbit       = out_bit;
  assign bus.rbit_valid = out_valid;
  assign bus.stuck      = stuck_flag;

endmodule

// File: tb/tb_rbit_src.sv
// tb_rbit_src: randomized self-checking bench for rbit_src.
// Two instances: dut (defaults, WARMUP=16, REP_LIMIT=20) and dut3
// (WARMUP=4, REP_LIMIT=3) so the health test can be exercised.
module tb_rbit_src;

  localparam int W0 = 16;
  localparam int R0 = 20;
  localparam int W3 = 4;
  localparam int R3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rbit_src_if bus ();
  rbit_src_if bus3 ();

  rbit_src #(.WARMUP(W0), .REP_LIMIT(R0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  rbit_src #(.WARMUP(W3), .REP_LIMIT(R3)) dut3 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus3)
  );

  // Reference model: counts remaining discarded steps, tracks raw run length
  // and collects VN pairs, all derived from the behavioural rules.
  typedef struct {
    int unsigned lfsr;
    bit          active;
    int          discard;
    int          run_len;
    bit          last;
    bit          stuck;
    bit          bitv;
    bit          valid;
    int          pair_cnt;
    bit          pair_first;
  } model_t;

  model_t m0;
  model_t m3;
  int     vectors = 0;
  int     miscompares = 0;
  bit     ref_bits[8];

  function automatic bit lfsr_next(inout int unsigned s);
    bit fb;
    fb = bit'(((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 32'd1);
    s  = ((s << 1) | 32'(fb)) & 32'hFFFF;
    return fb;
  endfunction

  function automatic void model_step(inout model_t m, input bit rstn, input bit en,
                                     input bit sl, input logic [15:0] sd,
                                     input int warmup, input int rep_limit);
    bit b;
    bit cand;
    bit cbit;
    cand = 1'b0;
    cbit = 1'b0;
    if (!rstn) begin
      m.lfsr = 32'hACE1; m.active = 1'b0; m.discard = 0; m.run_len = 0; m.last = 1'b0;
      m.stuck = 1'b0; m.bitv = 1'b0; m.valid = 1'b0; m.pair_cnt = 0; m.pair_first = 1'b0;
    end else if (sl) begin
      m.lfsr = (sd == 16'h0) ? 32'hACE1 : {16'h0, sd};
      m.active = en; m.discard = warmup; m.run_len = 0; m.stuck = 1'b0;
      m.valid = 1'b0; m.pair_cnt = 0;
    end else if (!en) begin
      m.active = 1'b0; m.valid = 1'b0; m.pair_cnt = 0;
    end else if (!m.active) begin
      m.active = 1'b1; m.discard = warmup; m.valid = 1'b0;
    end else if (m.discard > 0) begin
      b = lfsr_next(m.lfsr);
      m.discard = m.discard - 1;
      m.valid = 1'b0;
    end else begin
      b = lfsr_next(m.lfsr);
      if (m.run_len == 0 || b != m.last) m.run_len = 1;
      else m.run_len = m.run_len + 1;
      m.last = b;
      if (m.run_len >= rep_limit) m.stuck = 1'b1;
`ifdef RBIT_VN_EN
      if (m.pair_cnt == 0) begin
        m.pair_first = b;
        m.pair_cnt = 1;
      end else begin
        m.pair_cnt = 0;
        cand = (m.pair_first != b);
        cbit = m.pair_first;
      end
`else
      cand = 1'b1;
      cbit = b;
`endif
      if (cand && !m.stuck) begin
        m.bitv = cbit;
        m.valid = 1'b1;
      end else begin
        m.valid = 1'b0;
      end
    end
  endfunction

  // One rising edge: both models see the inputs present at that edge
  task automatic tick();
    @(posedge clk);
    model_step(m0, rst_n, bus.en, bus.seed_load, bus.seed, W0, R0);
    model_step(m3, rst_n, bus3.en, bus3.seed_load, bus3.seed, W3, R3);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b0;  bus.seed_load = 1'b0;  bus.seed = 16'h0;
    bus3.en = 1'b0; bus3.seed_load = 1'b0; bus3.seed = 16'h0;
    tick();
    tick();
    vectors++;
    if (bus.rbit !== 1'b0 || bus.rbit_valid !== 1'b0 || bus.stuck !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: got rbit=%b valid=%b stuck=%b, want 0 0 0", bus.rbit, bus.rbit_valid, bus.stuck);
    end
    vectors++;
    if (dut.u_lfsr.lfsr !== 16'hACE1) begin
      miscompares++;
      $display("FAIL reset_lfsr: got %h, want ace1", dut.u_lfsr.lfsr);
    end
    vectors++;
    if (bus3.rbit !== 1'b0 || bus3.rbit_valid !== 1'b0 || bus3.stuck !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out3: got rbit=%b valid=%b stuck=%b, want 0 0 0", bus3.rbit, bus3.rbit_valid, bus3.stuck);
    end
  endtask

  task automatic test_warmup();
    int got;
    got = 0;
    rst_n = 1'b1;
    bus.en = 1'b1;
    for (int e = 1; e <= 80; e++) begin
      tick();
      if (e == 2) begin
        vectors++;
        if (dut.u_lfsr.lfsr !== 16'h59C3) begin
          miscompares++;
          $display("FAIL first_step: got %h, want 59c3", dut.u_lfsr.lfsr);
        end
      end
`ifndef RBIT_VN_EN
      if (e <= W0 + 2) begin
        vectors++;
        if (bus.rbit_valid !== (e == W0 + 2)) begin
          miscompares++;
          $display("FAIL warm_latency: edge %0d got valid=%b, want %b", e, bus.rbit_valid, (e == W0 + 2));
        end
      end
`endif
      vectors++;
      if (bus.rbit_valid !== m0.valid || bus.rbit !== m0.bitv || bus.stuck !== m0.stuck) begin
        miscompares++;
        $display("FAIL warm_model: edge %0d got v=%b b=%b s=%b, want v=%b b=%b s=%b", e,
                 bus.rbit_valid, bus.rbit, bus.stuck, m0.valid, m0.bitv, m0.stuck);
      end
      if (m0.valid && got < 8) begin
        ref_bits[got] = m0.bitv;
        got++;
      end
    end
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL warm_bits: got %0d reference bits, want 8", got);
    end
  endtask

  task automatic test_seed_zero();
    int got;
    int n;
    int first;
    got = 0; n = 0; first = 0;
    bus.seed = 16'h0;
    bus.seed_load = 1'b1;
    tick();
    bus.seed_load = 1'b0;
    vectors++;
    if (dut.u_lfsr.lfsr !== 16'hACE1 || bus.rbit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL seed0_load: got lfsr=%h valid=%b, want ace1 0", dut.u_lfsr.lfsr, bus.rbit_valid);
    end
    while (got < 8 && n < 200) begin
      tick();
      n++;
      vectors++;
      if (bus.rbit_valid !== m0.valid || bus.rbit !== m0.bitv) begin
        miscompares++;
        $display("FAIL seed0_model: cycle %0d got v=%b b=%b, want v=%b b=%b", n, bus.rbit_valid, bus.rbit, m0.valid, m0.bitv);
      end
      if (bus.rbit_valid === 1'b1) begin
        if (first == 0) first = n;
        vectors++;
        if (bus.rbit !== ref_bits[got]) begin
          miscompares++;
          $display("FAIL seed0_seq: bit %0d got %b, want %b", got, bus.rbit, ref_bits[got]);
        end
        got++;
      end
    end
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL seed0_timeout: got %0d bits, want 8", got);
    end
`ifndef RBIT_VN_EN
    vectors++;
    if (first != W0 + 1) begin
      miscompares++;
      $display("FAIL seed0_latency: first valid at %0d, want %0d", first, W0 + 1);
    end
`endif
  endtask

  task automatic test_en_pause();
    int unsigned frozen;
    int first;
    first = 0;
    frozen = m0.lfsr;
    bus.en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      vectors++;
      if (bus.rbit_valid !== 1'b0 || dut.u_lfsr.lfsr !== 16'(frozen)) begin
        miscompares++;
        $display("FAIL pause: cycle %0d got valid=%b lfsr=%h, want 0 %h", i, bus.rbit_valid, dut.u_lfsr.lfsr, 16'(frozen));
      end
    end
    bus.en = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (first == 0 && bus.rbit_valid === 1'b1) first = e;
      vectors++;
      if (bus.rbit_valid !== m0.valid || bus.rbit !== m0.bitv || bus.stuck !== m0.stuck) begin
        miscompares++;
        $display("FAIL resume_model: edge %0d got v=%b b=%b s=%b, want v=%b b=%b s=%b", e,
                 bus.rbit_valid, bus.rbit, bus.stuck, m0.valid, m0.bitv, m0.stuck);
      end
    end
`ifndef RBIT_VN_EN
    vectors++;
    if (first != W0 + 2) begin
      miscompares++;
      $display("FAIL resume_latency: first valid at edge %0d, want %0d", first, W0 + 2);
    end
`endif
  endtask

  task automatic test_stuck();
    int n;
    n = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;
    tick();
    rst_n = 1'b1;
    bus3.en = 1'b1;
    while (bus3.stuck !== 1'b1 && n < 300) begin
      tick();
      n++;
      vectors++;
      if (bus3.rbit_valid !== m3.valid || bus3.rbit !== m3.bitv || bus3.stuck !== m3.stuck) begin
        miscompares++;
        $display("FAIL stuck_model: cycle %0d got v=%b b=%b s=%b, want v=%b b=%b s=%b", n,
                 bus3.rbit_valid, bus3.rbit, bus3.stuck, m3.valid, m3.bitv, m3.stuck);
      end
    end
    vectors++;
    if (bus3.stuck !== 1'b1 || bus3.rbit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stuck_trip: got stuck=%b valid=%b, want 1 0", bus3.stuck, bus3.rbit_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (bus3.stuck !== 1'b1 || bus3.rbit_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stuck_sticky: got stuck=%b valid=%b, want 1 0", bus3.stuck, bus3.rbit_valid);
      end
    end
    bus3.seed = 16'h1234;
    bus3.seed_load = 1'b1;
    tick();
    bus3.seed_load = 1'b0;
    vectors++;
    if (bus3.stuck !== 1'b0 || bus3.rbit_valid !== 1'b0 || dut3.u_lfsr.lfsr !== 16'h1234) begin
      miscompares++;
      $display("FAIL stuck_clear: got stuck=%b valid=%b lfsr=%h, want 0 0 1234", bus3.stuck, bus3.rbit_valid, dut3.u_lfsr.lfsr);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (bus3.rbit_valid !== m3.valid || bus3.rbit !== m3.bitv || bus3.stuck !== m3.stuck) begin
        miscompares++;
        $display("FAIL stuck_rewarm: cycle %0d got v=%b b=%b s=%b, want v=%b b=%b s=%b", i,
                 bus3.rbit_valid, bus3.rbit, bus3.stuck, m3.valid, m3.bitv, m3.stuck);
      end
    end
    bus3.en = 1'b0;
  endtask

  task automatic test_seed_at_run_edge();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.en = 1'b1;
    for (int e = 1; e <= W0; e++) tick();
    // The next edge is the one that would move WARM to RUN
    bus.seed = 16'hBEEF;
    bus.seed_load = 1'b1;
    tick();
    bus.seed_load = 1'b0;
    vectors++;
    if (bus.rbit_valid !== 1'b0 || dut.u_lfsr.lfsr !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL edge_seed: got valid=%b lfsr=%h, want 0 beef", bus.rbit_valid, dut.u_lfsr.lfsr);
    end
    for (int k = 1; k <= W0 + 1; k++) begin
      tick();
      if (k <= W0) begin
        vectors++;
        if (bus.rbit_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL edge_rewarm: step %0d got valid=%b, want 0", k, bus.rbit_valid);
        end
      end
`ifndef RBIT_VN_EN
      else begin
        vectors++;
        if (bus.rbit_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL edge_first: got valid=%b, want 1", bus.rbit_valid);
        end
      end
`endif
      vectors++;
      if (bus.rbit_valid !== m0.valid || bus.rbit !== m0.bitv) begin
        miscompares++;
        $display("FAIL edge_model: step %0d got v=%b b=%b, want v=%b b=%b", k, bus.rbit_valid, bus.rbit, m0.valid, m0.bitv);
      end
    end
  endtask

  task automatic test_random();
    bit prev0;
    prev0 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.en         = ($urandom_range(0, 99) < 93);
      bus.seed_load  = ($urandom_range(0, 99) < 2);
      bus.seed       = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      bus3.en        = ($urandom_range(0, 99) < 90);
      bus3.seed_load = ($urandom_range(0, 99) < 4);
      bus3.seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick();
      vectors++;
      if (bus.rbit_valid !== m0.valid || bus.rbit !== m0.bitv || bus.stuck !== m0.stuck) begin
        miscompares++;
        $display("FAIL rand0: cycle %0d got v=%b b=%b s=%b, want v=%b b=%b s=%b", i,
                 bus.rbit_valid, bus.rbit, bus.stuck, m0.valid, m0.bitv, m0.stuck);
      end
      vectors++;
      if (bus3.rbit_valid !== m3.valid || bus3.rbit !== m3.bitv || bus3.stuck !== m3.stuck) begin
        miscompares++;
        $display("FAIL rand3: cycle %0d got v=%b b=%b s=%b, want v=%b b=%b s=%b", i,
                 bus3.rbit_valid, bus3.rbit, bus3.stuck, m3.valid, m3.bitv, m3.stuck);
      end
`ifdef RBIT_VN_EN
      vectors++;
      if (prev0 && bus.rbit_valid === 1'b1) begin
        miscompares++;
        $display("FAIL vn_spacing: cycle %0d got two consecutive valids, want none", i);
      end
`endif
      prev0 = (bus.rbit_valid === 1'b1);
    end
    bus.seed_load  = 1'b0;
    bus3.seed_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_seed_zero();
    test_en_pause();
    test_stuck();
    test_seed_at_run_edge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
